// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA receive: sync recovery, timing measurement, lock and pixel capture
module vga_capture #(
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 12
) (
  input  logic             clock,
  input  logic             res,
  input  logic             hsync_n,
  input  logic             vsync_n,
  input  logic [3:0]       red,
  input  logic [3:0]       green,
  input  logic [3:0]       blue,
  output logic             pix_valid,
  output logic [9:0]       pix_x,
  output logic [9:0]       pix_y,
  output logic [11:0]      pix_rgb,
  output logic             frame_start,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic             locked
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_HS    = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] L_HE    = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] L_VS    = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] L_VE    = CNT_W'(V_START + V_ACTIVE);

  logic             r_hs_s1, r_hs_s2, r_hs_prev;
  logic             r_vs_s1, r_vs_s2, r_vs_prev;
  logic [11:0]      r_rgb_s1, r_rgb_s2;
  logic [CNT_W-1:0] r_hcnt, r_vcnt;
  logic             r_arm;
  logic [CNT_W-1:0] r_ref_h, r_ref_v;
  state_t           r_state;

  logic             w_hfall, w_vfall, w_origin, w_sat, w_match, w_reload, w_valid;
  logic [CNT_W-1:0] w_line_len, w_frame_len, w_hcnt_nxt, w_vcnt_nxt;
  state_t           w_state_nxt;

  // Sync flops are seeded high so a line held high at release never looks like a falling edge
  always_ff @(posedge clock or posedge res) begin
    if (res) begin
      r_hs_s1   <= 1'b1;
      r_hs_s2   <= 1'b1;
      r_hs_prev <= 1'b1;
      r_vs_s1   <= 1'b1;
      r_vs_s2   <= 1'b1;
      r_vs_prev <= 1'b1;
      r_rgb_s1  <= '0;
      r_rgb_s2  <= '0;
    end else begin
      r_hs_s1   <= hsync_n;
      r_hs_s2   <= r_hs_s1;
      r_hs_prev <= r_hs_s2;
      r_vs_s1   <= vsync_n;
      r_vs_s2   <= r_vs_s1;
      r_vs_prev <= r_vs_s2;
      r_rgb_s1  <= {red, green, blue};
      r_rgb_s2  <= r_rgb_s1;
    end
  end

  assign w_hfall     = r_hs_prev & ~r_hs_s2;
  assign w_vfall     = r_vs_prev & ~r_vs_s2;
  assign w_origin    = w_hfall & (r_arm | w_vfall);
  assign w_sat       = (r_hcnt == CNT_MAX);
  assign w_line_len  = r_hcnt + CNT_ONE;
  assign w_frame_len = r_vcnt + CNT_ONE;
  assign w_hcnt_nxt  = w_hfall ? '0 : (w_sat ? r_hcnt : r_hcnt + CNT_ONE);
  assign w_vcnt_nxt  = w_origin ? '0 :
                       ((w_hfall && (r_vcnt != CNT_MAX)) ? r_vcnt + CNT_ONE : r_vcnt);
  assign w_match     = (w_line_len == r_ref_h) && (w_frame_len == r_ref_v);

  // Horizontal/vertical position counters and the vsync arm flag
  always_ff @(posedge clock or posedge res) begin
    if (res) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
      r_arm  <= 1'b0;
    end else begin
      r_hcnt <= w_hcnt_nxt;
      r_vcnt <= w_vcnt_nxt;
      if (w_origin)
        r_arm <= 1'b0;
      else if (w_vfall)
        r_arm <= 1'b1;
    end
  end

  // Lock FSM next state; saturation (sync lost) overrides any frame-origin decision
  always_comb begin
    w_state_nxt = r_state;
    w_reload    = 1'b0;
    if (w_sat) begin
      w_state_nxt = SEARCH;
    end else if (w_origin) begin
      case (r_state)
        SEARCH: begin
          w_state_nxt = MEASURE;
          w_reload    = 1'b1;
        end
        MEASURE: begin
          if (w_match) w_state_nxt = LOCKED;
          else         w_reload    = 1'b1;
        end
        LOCKED: begin
          if (!w_match) begin
            w_state_nxt = MEASURE;
            w_reload    = 1'b1;
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  // FSM state, reference measurements and published totals
  always_ff @(posedge clock or posedge res) begin
    if (res) begin
      r_state <= SEARCH;
      r_ref_h <= '0;
      r_ref_v <= '0;
      h_total <= '0;
      v_total <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_reload) begin
        r_ref_h <= w_line_len;
        r_ref_v <= w_frame_len;
      end
      if (w_origin && !w_sat && (r_state != SEARCH)) begin
        h_total <= w_reload ? w_line_len  : r_ref_h;
        v_total <= w_reload ? w_frame_len : r_ref_v;
      end
    end
  end

  // Window test uses next-cycle counters so coordinates line up with the delayed RGB
  assign w_valid = (w_state_nxt == LOCKED) &&
                   (w_hcnt_nxt >= L_HS) && (w_hcnt_nxt < L_HE) &&
                   (w_vcnt_nxt >= L_VS) && (w_vcnt_nxt < L_VE);

  // Registered pixel outputs, zeroed outside the active window
  always_ff @(posedge clock or posedge res) begin
    if (res) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
    end else begin
      pix_valid   <= w_valid;
      pix_x       <= w_valid ? (w_hcnt_nxt[9:0] - L_HS[9:0]) : '0;
      pix_y       <= w_valid ? (w_vcnt_nxt[9:0] - L_VS[9:0]) : '0;
      pix_rgb     <= w_valid ? r_rgb_s2 : '0;
      frame_start <= w_valid && (w_hcnt_nxt == L_HS) && (w_vcnt_nxt == L_VS);
      locked      <= (w_state_nxt == LOCKED);
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - scoreboard bench for vga_capture on a reduced raster
module tb_vga_capture;

  localparam int HS    = 6;
  localparam int HA    = 12;
  localparam int VS    = 3;
  localparam int VA    = 6;
  localparam int HSYNC = 3;
  localparam int NL    = 12;
  localparam int CW    = 12;

  typedef struct packed {
    logic [31:0] pix;
    logic [31:0] cyc;
  } exp_t;

  logic          clock = 1'b0;
  logic          res = 1'b1;
  logic          hsync_n = 1'b1;
  logic          vsync_n = 1'b1;
  logic [3:0]    red = '0, green = '0, blue = '0;
  logic          pix_valid, frame_start, locked;
  logic [9:0]    pix_x, pix_y;
  logic [11:0]   pix_rgb;
  logic [CW-1:0] h_total, v_total;

  vga_capture #(
    .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_ACTIVE(VA), .CNT_W(CW)
  ) dut (
    .clock(clock), .res(res), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .h_total(h_total), .v_total(v_total), .locked(locked)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  int   checks = 0, failures = 0;
  int   valid_cnt = 0, fs_cnt = 0, fs_exp_total = 0;
  int   rises = 0, falls = 0;
  logic lock_prev = 1'b0;
  exp_t sbq[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every valid pixel, tracks lock transitions
  always @(negedge clock) begin
    exp_t e;
    if (pix_valid) begin
      valid_cnt++;
      if (sbq.size() == 0) begin
        check_val("unexpected_pix", {31'd0, pix_valid}, 64'd0);
      end else begin
        e = sbq.pop_front();
        check_val("pix", {32'd0, pix_x, pix_y, pix_rgb}, {32'd0, e.pix});
        check_val("latency", 64'(cyc) - 64'(e.cyc), 64'd3);
      end
    end
    if (frame_start) begin
      fs_cnt++;
      check_val("fs_at_origin", {43'd0, pix_valid, pix_x, pix_y}, {43'd0, 1'b1, 20'd0});
    end
    if (locked && !lock_prev) rises++;
    if (!locked && lock_prev) falls++;
    lock_prev = locked;
  end

  task automatic send_frame(input int hlen, input bit early_vs, input bit do_rst,
                            input bit exp_lock, input int exp_h, input bit lat_pat,
                            input int fidx);
    int   v0, f0, pushed, fs_exp;
    bit   lk, active;
    logic [9:0]  xv, yv;
    logic [11:0] rgb;
    exp_t e;
    v0 = valid_cnt;
    f0 = fs_cnt;
    pushed = 0;
    fs_exp = 0;
    lk = exp_lock;
    for (int l = 0; l < NL; l++) begin
      for (int c = 0; c < hlen; c++) begin
        @(posedge clock);
        #1;
        if (res) res = 1'b0;
        if (do_rst && l == VS + 2 && c == HS + 3) begin
          res = 1'b1;
          #1;
          check_val("rst_pix", {29'd0, pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked},
                    64'd0);
          check_val("rst_totals", {40'd0, h_total, v_total}, 64'd0);
          pushed -= sbq.size();
          sbq.delete();
          lk = 1'b0;
        end
        hsync_n = !(c < HSYNC);
        vsync_n = !((l < 2) || (early_vs && l == NL - 1 && c >= hlen / 2));
        active  = (l >= VS) && (l < VS + VA) && (c >= HS) && (c < HS + HA);
        xv = 10'(c - HS);
        yv = 10'(l - VS);
        if (!active)
          rgb = 12'($urandom);
        else if (lat_pat)
          rgb = (xv == 0 && yv == 0) ? 12'hF00 : 12'h000;
        else
          rgb = {yv[3:0], xv[3:0] ^ 4'(fidx), xv[3:0]};
        {red, green, blue} = rgb;
        if (active && lk) begin
          e.pix = {xv, yv, rgb};
          e.cyc = 32'(cyc);
          sbq.push_back(e);
          pushed++;
          if (xv == 0 && yv == 0) fs_exp++;
        end
        if (l == VS && c == 0) begin
          check_val("locked_mid", {63'd0, locked}, {63'd0, exp_lock});
          if (exp_lock) begin
            check_val("h_total", 64'(h_total), 64'(exp_h));
            check_val("v_total", 64'(v_total), 64'(NL));
          end
        end
      end
    end
    check_val("valid_per_frame", 64'(valid_cnt - v0), 64'(pushed));
    check_val("fs_per_frame", 64'(fs_cnt - f0), 64'(fs_exp));
    fs_exp_total += fs_exp;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_val("reset_pix", {29'd0, pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked}, 64'd0);
    check_val("reset_totals", {40'd0, h_total, v_total}, 64'd0);
    // Standard raster: lock at the third frame origin
    send_frame(24, 0, 0, 0, 0,  0, 0);
    send_frame(24, 0, 0, 0, 0,  0, 1);
    send_frame(24, 0, 0, 1, 24, 0, 2);
    send_frame(24, 0, 0, 1, 24, 1, 3);
    // vsync falling mid-line in the last line of a frame
    send_frame(24, 1, 0, 1, 24, 0, 4);
    send_frame(24, 0, 0, 1, 24, 0, 5);
    // Line length change: lock lost one origin later, regained one frame after
    send_frame(25, 0, 0, 1, 24, 0, 6);
    send_frame(25, 0, 0, 0, 0,  0, 7);
    send_frame(25, 0, 0, 1, 25, 0, 8);
    // No hsync at all: counter saturates and lock drops
    for (int i = 0; i < 5000; i++) begin
      @(posedge clock);
      #1;
      hsync_n = 1'b1;
      vsync_n = 1'b1;
      {red, green, blue} = 12'($urandom);
      if (i == 4095) check_val("sat_unlock", {63'd0, locked}, 64'd0);
    end
    send_frame(24, 0, 0, 0, 0,  0, 9);
    send_frame(24, 0, 0, 0, 0,  0, 10);
    send_frame(24, 0, 0, 1, 24, 0, 11);
    // One-clock reset in the middle of an active line
    send_frame(24, 0, 1, 1, 24, 0, 12);
    send_frame(24, 0, 0, 0, 0,  0, 13);
    send_frame(24, 0, 0, 0, 0,  0, 14);
    send_frame(24, 0, 0, 1, 24, 0, 15);
    repeat (8) @(posedge clock);
    #1;
    check_val("sb_empty", 64'(sbq.size()), 64'd0);
    check_val("lock_rises", 64'(rises), 64'd4);
    check_val("lock_falls", 64'(falls), 64'd3);
    check_val("fs_total", 64'(fs_cnt), 64'(fs_exp_total));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
